// File: rtl/mem_stage.sv
// Unified instruction/data memory stage for the multicycle MIPS core.
// Holds the word RAM, the instruction register (IR) and the memory data register (MDR).
module mem_stage #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lord,
    input  logic [31:0] pc,
    input  logic [31:0] aluout,
    input  logic        irwrite,
    input  logic        memwrite,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] data,
    output logic        misalign,
    output logic        oob
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   ram [DEPTH];
    logic [31:0]   addr;
    logic [AW-1:0] index;
    logic          inrange;
    logic          aligned;
    logic          active;
    logic          write_en;

    logic [31:0]   instr_q, instr_d;
    logic [31:0]   data_q, data_d;
    logic          misalign_q, misalign_d;
    logic          oob_q, oob_d;

    always_comb begin
        addr     = lord ? aluout : pc;
        index    = addr[AW+1:2];
        // DEPTH is a power of two, so in range simply means no bits above the word index
        inrange  = (addr[31:AW+2] == '0);
        aligned  = (addr[1:0] == 2'b00);
        active   = irwrite | memwrite | lord;
        write_en = memwrite & inrange & aligned & reset;
        readdata = inrange ? ram[index] : 32'h0;
    end

    always_comb begin
        instr_d    = irwrite ? readdata : instr_q;
        data_d     = readdata;
        misalign_d = misalign_q | (active & ~aligned);
        oob_d      = oob_q | (active & ~inrange);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q    <= 32'h0;
            data_q     <= 32'h0;
            misalign_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            data_q     <= data_d;
            misalign_q <= misalign_d;
            oob_q      <= oob_d;
        end
    end

    // RAM is never reset; IR/MDR see the pre-write word because the read is combinational
    always_ff @(posedge clk) begin
        if (write_en) begin
            ram[index] <= writedata;
        end
    end

    assign instr    = instr_q;
    assign op       = instr_q[31:26];
    assign funct    = instr_q[5:0];
    assign data     = data_q;
    assign misalign = misalign_q;
    assign oob      = oob_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against an associative-array memory model.
module tb_mem_stage;
    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic        lord;
    logic [31:0] pc;
    logic [31:0] aluout;
    logic        irwrite;
    logic        memwrite;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] data;
    logic        misalign;
    logic        oob;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_mem [int unsigned];
    logic [31:0] m_instr;
    bit          m_instr_known;
    logic [31:0] m_data;
    bit          m_data_known;
    bit          m_mis;
    bit          m_oob;

    mem_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .lord(lord), .pc(pc), .aluout(aluout),
        .irwrite(irwrite), .memwrite(memwrite), .writedata(writedata),
        .readdata(readdata), .instr(instr), .op(op), .funct(funct),
        .data(data), .misalign(misalign), .oob(oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic l, input logic [31:0] p, input logic [31:0] a,
                         input logic iw, input logic mw, input logic [31:0] wd);
        lord = l; pc = p; aluout = a; irwrite = iw; memwrite = mw; writedata = wd;
    endtask

    function automatic bit exp_read(output logic [31:0] v);
        logic [31:0] a;
        int unsigned w;
        a = lord ? aluout : pc;
        w = a >> 2;
        v = 32'h0;
        if (w >= DEPTH) return 1'b1;
        if (m_mem.exists(w)) begin
            v = m_mem[w];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_instr = 32'h0; m_instr_known = 1'b1;
        m_data  = 32'h0; m_data_known  = 1'b1;
        m_mis   = 1'b0;  m_oob = 1'b0;
    endtask

    // advance one rising edge, updating the model from the inputs seen at that edge
    task automatic tick();
        logic [31:0] rd;
        logic [31:0] a;
        int unsigned w;
        bit known;
        a = lord ? aluout : pc;
        w = a >> 2;
        known = exp_read(rd);
        if (reset) begin
            if (irwrite) begin m_instr = rd; m_instr_known = known; end
            m_data = rd; m_data_known = known;
            if (irwrite | memwrite | lord) begin
                if (a[1:0] != 2'b00) m_mis = 1'b1;
                if (w >= DEPTH) m_oob = 1'b1;
            end
            if (memwrite && w < DEPTH && a[1:0] == 2'b00) m_mem[w] = writedata;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
        #1;
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got=%h exp=0", instr); end
        checks++; if (data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", data); end
        checks++; if (op !== 6'h0 || funct !== 6'h0) begin errors++; $display("[TB] FAIL reset_op_funct got=%h/%h exp=0/0", op, funct); end
        checks++; if (misalign !== 1'b0 || oob !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got=%b%b exp=00", misalign, oob); end
        tick();
        tick();
        checks++; if (instr !== 32'h0 || data !== 32'h0) begin errors++; $display("[TB] FAIL reset_held got=%h/%h exp=0/0", instr, data); end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (instr !== 32'h0 || data !== 32'h0 || op !== 6'h0) begin errors++; $display("[TB] FAIL reset_release got=%h/%h/%h exp=0", instr, data, op); end
        checks++; if (misalign !== 1'b0 || oob !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_flags got=%b%b exp=00", misalign, oob); end
    endtask

    task automatic test_fetch();
        drive(0, 32'h10, 32'h0, 0, 1, 32'h8C0A0004);
        tick();
        drive(0, 32'h10, 32'h0, 1, 0, 32'h0);
        #1;
        checks++; if (readdata !== 32'h8C0A0004) begin errors++; $display("[TB] FAIL fetch_read got=%h exp=8c0a0004", readdata); end
        tick();
        checks++; if (instr !== 32'h8C0A0004) begin errors++; $display("[TB] FAIL fetch_instr got=%h exp=8c0a0004", instr); end
        checks++; if (op !== 6'b100011 || funct !== 6'h04) begin errors++; $display("[TB] FAIL fetch_op_funct got=%b/%h exp=100011/04", op, funct); end
        drive(0, 32'h14, 32'h0, 0, 1, 32'h55AA55AA);
        tick();
        drive(0, 32'h14, 32'h0, 0, 0, 32'h0);
        tick();
        checks++; if (instr !== 32'h8C0A0004) begin errors++; $display("[TB] FAIL fetch_hold got=%h exp=8c0a0004", instr); end
    endtask

    task automatic test_load();
        drive(1, 32'h0, 32'h20, 0, 1, 32'hDEADBEEF);
        tick();
        drive(1, 32'h0, 32'h20, 0, 0, 32'h0);
        #1;
        checks++; if (readdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_read got=%h exp=deadbeef", readdata); end
        tick();
        checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_mdr got=%h exp=deadbeef", data); end
        checks++; if (instr !== 32'h8C0A0004) begin errors++; $display("[TB] FAIL load_ir_hold got=%h exp=8c0a0004", instr); end
    endtask

    task automatic test_store_reload();
        drive(1, 32'h0, 32'h24, 0, 1, 32'h12345678);
        tick();
        drive(1, 32'h0, 32'h24, 0, 0, 32'h0);
        #1;
        checks++; if (readdata !== 32'h12345678) begin errors++; $display("[TB] FAIL store_read got=%h exp=12345678", readdata); end
        tick();
        checks++; if (data !== 32'h12345678) begin errors++; $display("[TB] FAIL store_mdr got=%h exp=12345678", data); end
    endtask

    task automatic test_back_to_back();
        drive(0, 32'h30, 32'h0, 0, 1, 32'h11111111);
        tick();
        drive(0, 32'h30, 32'h0, 1, 1, 32'h22222222);
        tick();
        checks++; if (instr !== 32'h11111111) begin errors++; $display("[TB] FAIL rbw_instr got=%h exp=11111111", instr); end
        checks++; if (data !== 32'h11111111) begin errors++; $display("[TB] FAIL rbw_mdr got=%h exp=11111111", data); end
        drive(0, 32'h30, 32'h0, 0, 0, 32'h0);
        #1;
        checks++; if (readdata !== 32'h22222222) begin errors++; $display("[TB] FAIL rbw_ram12 got=%h exp=22222222", readdata); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 31) * 4, $urandom_range(0, 31) * 4,
                  $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom);
            #1;
            if (exp_read(rd)) begin
                checks++; if (readdata !== rd) begin errors++; $display("[TB] FAIL rand_read i=%0d got=%h exp=%h", i, readdata, rd); end
            end
            tick();
            if (m_instr_known) begin
                checks++; if (instr !== m_instr) begin errors++; $display("[TB] FAIL rand_instr i=%0d got=%h exp=%h", i, instr, m_instr); end
            end
            if (m_data_known) begin
                checks++; if (data !== m_data) begin errors++; $display("[TB] FAIL rand_mdr i=%0d got=%h exp=%h", i, data, m_data); end
            end
            checks++; if (misalign !== m_mis || oob !== m_oob) begin errors++; $display("[TB] FAIL rand_flags i=%0d got=%b%b exp=%b%b", i, misalign, oob, m_mis, m_oob); end
        end
    endtask

    task automatic test_errors();
        drive(1, 32'h0, 32'h40, 0, 1, 32'hA5A50016);
        tick();
        drive(1, 32'h0, 32'h42, 0, 1, 32'hFFFF0000);
        #1;
        checks++; if (readdata !== 32'hA5A50016) begin errors++; $display("[TB] FAIL misalign_read got=%h exp=a5a50016", readdata); end
        tick();
        checks++; if (misalign !== 1'b1 || oob !== 1'b0) begin errors++; $display("[TB] FAIL misalign_flags got=%b%b exp=10", misalign, oob); end
        drive(1, 32'h0, 32'h40, 0, 0, 32'h0);
        #1;
        checks++; if (readdata !== 32'hA5A50016) begin errors++; $display("[TB] FAIL misalign_nowrite got=%h exp=a5a50016", readdata); end
        drive(1, 32'h0, 4 * DEPTH, 0, 0, 32'h0);
        #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("[TB] FAIL oob_read got=%h exp=0", readdata); end
        tick();
        checks++; if (oob !== 1'b1) begin errors++; $display("[TB] FAIL oob_flag got=%b exp=1", oob); end
        drive(1, 32'h0, 4 * DEPTH + 32'h40, 0, 1, 32'h0BAD0BAD);
        tick();
        drive(1, 32'h0, 32'h40, 0, 0, 32'h0);
        #1;
        checks++; if (readdata !== 32'hA5A50016) begin errors++; $display("[TB] FAIL oob_nowrite got=%h exp=a5a50016", readdata); end
        drive(0, 32'h40, 32'h0, 1, 0, 32'h0);
        tick();
        drive(0, 32'h44, 32'h0, 0, 0, 32'h0);
        tick();
        checks++; if (misalign !== 1'b1 || oob !== 1'b1) begin errors++; $display("[TB] FAIL flags_sticky got=%b%b exp=11", misalign, oob); end
        checks++; if (instr !== 32'hA5A50016) begin errors++; $display("[TB] FAIL clean_fetch got=%h exp=a5a50016", instr); end
        reset = 1'b0;
        model_reset();
        drive(1, 32'h0, 32'h40, 1, 1, 32'h77777777);
        #1;
        checks++; if (misalign !== 1'b0 || oob !== 1'b0 || instr !== 32'h0) begin errors++; $display("[TB] FAIL flags_reset got=%b%b/%h exp=00/0", misalign, oob, instr); end
        tick();
        reset = 1'b1;
        drive(1, 32'h0, 32'h40, 0, 0, 32'h0);
        #1;
        checks++; if (readdata !== 32'hA5A50016) begin errors++; $display("[TB] FAIL reset_blocks_write got=%h exp=a5a50016", readdata); end
        tick();
        checks++; if (data !== 32'hA5A50016 || misalign !== 1'b0 || oob !== 1'b0) begin errors++; $display("[TB] FAIL post_reset got=%h/%b%b exp=a5a50016/00", data, misalign, oob); end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        model_reset();
        test_reset();
        test_fetch();
        test_load();
        test_store_reload();
        test_back_to_back();
        test_random();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
